serial_receiver: RTL
====================

# serial_receiver

Deserializes the single-wire audio/keyboard link frame format: idle-low line, one start bit (1), then a 40-bit payload MSB first, one bit per clock. This is the receive-side counterpart of the 40-bit frame serializer. It sits directly downstream of the serial line and presents each completed frame to the parallel side through a one-entry valid/ready holding register, with overrun detection.

## Interface
- FRAME_BITS, 40, payload bits per frame (start bit excluded)
- clk  in  1  bit clock; all sampling on rising edge; `sin` is driven by the far end on the falling edge of the same clock
- n_reset  in  1  asynchronous, active-low reset
- sin  in  1  serial input, idle 0
- out_data  out  FRAME_BITS  last accepted frame, MSB = first payload bit received
- out_valid  out  1  holding register full
- out_ready  in  1  consumer accepts `out_data` at a rising edge where `out_valid`=1
- overrun  out  1  one-cycle pulse: a frame completed but was dropped because the holding register was full
- framing_err  out  1  one-cycle pulse: stop check failed (tied 0 without the macro)

## Operation
- States: IDLE, DATA, STOP (STOP exists only with the macro).
- IDLE: `sin`=1 sampled → DATA, count←0; `sin`=0 → stay.
- DATA: shift `sin` into shift register LSB (left shift), count++; on the edge sampling payload bit FRAME_BITS-1 (count = FRAME_BITS-1):
  - without macro → frame complete, IDLE;
  - with macro → STOP.
- STOP: `sin`=0 → frame complete, IDLE; `sin`=1 → frame discarded, framing_err pulse, IDLE. That 1 is not treated as a start bit.
- Frame complete:
  - if out_valid=0, or out_ready=1 in the same cycle → out_data←shift register, out_valid=1;
  - else → keep old data, overrun pulse.
- Accept: out_valid & out_ready with no completing frame → out_valid←0; out_data holds its value.
- Count width: $clog2(FRAME_BITS); no wrap is possible because DATA exits at FRAME_BITS-1.
- Reset: asserting n_reset at any time, including mid-frame, forces IDLE, count=0, shift register=0, out_data=0, out_valid=0, overrun=0, framing_err=0. The partial frame is lost.

## Timing
- Edge 0 samples the start bit; edges 1..FRAME_BITS sample the payload.
- Without macro: out_valid=1 after edge FRAME_BITS. Latency from start-bit edge = FRAME_BITS+1 edges (41).
- With macro: stop bit sampled at edge FRAME_BITS+1; out_valid=1 after that edge (42 edges).
- The earliest next start bit is sampled on the edge after the last payload bit (no macro) or after the stop bit (macro). Back-to-back frames need no idle gap.
- overrun and framing_err are registered and high for exactly one cycle, coincident with the completion edge.
- The valid/ready handshake has zero-cycle turnaround: a simultaneous accept and complete keeps out_valid high with the new data.

## Configuration
- RECEIVER_STOP_CHECK_EN defined: the STOP state is present. Each frame must be followed by a 0. Violations drop the frame and pulse framing_err.
- Undefined: the STOP state is absent, framing_err is constant 0, and the frame completes on the last payload bit.

## Structure
- Shared package `nextasic_serial_pkg` holds:
  - FRAME_BITS default (40), shared with the serializer;
  - `rx_state_t` enum {IDLE, DATA, STOP};
  - START_BIT = 1'b1 and IDLE_LEVEL = 1'b0 constants.
- One sub-module: `rx_holding_reg`, the one-entry valid/ready buffer with overrun generation. The FSM and shifter stay in the top.

## Test plan
- Reset, then drive 1 followed by 40'hD999999991 MSB first, with out_ready=0 → out_valid=1 at edge 41 (42 with macro), out_data=40'hD999999991, overrun=0.
- With the first frame held (out_ready=0), send 40'h9999999993 → overrun pulses once; out_data stays 40'hD999999991.
- Two frames back-to-back (D999999991, then 9999999993) with out_ready=1 throughout → both appear in order, no overrun, out_valid stays high across the simultaneous accept+complete edge.
- Macro build: after 40'h9999999993, drive sin=1 at the stop position → framing_err pulse, out_valid stays 0; the next edge with sin=0 stays IDLE (no false start).
- Assert n_reset at payload bit 20, release, then send 40'h0000000001 → only the second frame is delivered, out_data=40'h0000000001; all outputs read 0 during reset.
- Idle line (sin=0) for 100 cycles → out_valid, overrun and framing_err stay 0, and the state remains IDLE.

Source files
------------

// File: rtl/nextasic_serial_pkg.sv
// Shared definitions for the 40-bit single-wire link (serializer and receiver).
// Stop-bit checking in the receiver is enabled by RECEIVER_STOP_CHECK_EN.
package nextasic_serial_pkg;

    localparam int unsigned FRAME_BITS_DEFAULT = 40;

    localparam logic START_BIT  = 1'b1;
    localparam logic IDLE_LEVEL = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } rx_state_t;

endpackage

// File: rtl/rx_holding_reg.sv
// One-entry valid/ready holding register for completed frames.
// A completing frame is dropped, with an overrun pulse, when the entry is full and not being drained.
module rx_holding_reg #(
    parameter int unsigned W = 40
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic         frame_done,
    input  logic [W-1:0] frame_data,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         overrun
);

    logic can_load;

    // Zero-cycle turnaround: a simultaneous accept frees the entry for the new frame.
    assign can_load = !out_valid || out_ready;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (frame_done) begin
                if (can_load) begin
                    out_data  <= frame_data;
                    out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/serial_receiver.sv
// Single-wire frame deserializer: start bit, FRAME_BITS payload MSB first, optional stop check.
// Define RECEIVER_STOP_CHECK_EN to require a 0 stop bit after each frame.
module serial_receiver
    import nextasic_serial_pkg::*;
#(
    parameter int unsigned FRAME_BITS = FRAME_BITS_DEFAULT
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic                  sin,
    output logic [FRAME_BITS-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overrun,
    output logic                  framing_err
);

    localparam int unsigned COUNT_W = $clog2(FRAME_BITS);
    localparam logic [COUNT_W-1:0] LAST_BIT = COUNT_W'(FRAME_BITS - 1);

    rx_state_t               state_q, state_d;
    logic [COUNT_W-1:0]      count_q, count_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic [FRAME_BITS-1:0]   frame_data;
    logic                    frame_done;
`ifdef RECEIVER_STOP_CHECK_EN
    logic                    frame_bad;
    logic                    framing_err_q;
`endif

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= IDLE;
            count_q <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        shift_d    = shift_q;
        frame_done = 1'b0;
        frame_data = shift_q;
`ifdef RECEIVER_STOP_CHECK_EN
        frame_bad  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (sin == START_BIT) begin
                    state_d = DATA;
                    count_d = '0;
                end
            end
            DATA: begin
                shift_d = {shift_q[FRAME_BITS-2:0], sin};
                count_d = count_q + COUNT_W'(1);
                if (count_q == LAST_BIT) begin
                    count_d = '0;
`ifdef RECEIVER_STOP_CHECK_EN
                    state_d = STOP;
`else
                    // Last payload bit is still in flight; hand over the post-shift value.
                    state_d    = IDLE;
                    frame_done = 1'b1;
                    frame_data = shift_d;
`endif
                end
            end
`ifdef RECEIVER_STOP_CHECK_EN
            STOP: begin
                // A 1 here is a violation, never a start bit.
                state_d = IDLE;
                if (sin == IDLE_LEVEL) begin
                    frame_done = 1'b1;
                end else begin
                    frame_bad = 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

`ifdef RECEIVER_STOP_CHECK_EN
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            framing_err_q <= 1'b0;
        end else begin
            framing_err_q <= frame_bad;
        end
    end

    assign framing_err = framing_err_q;
`else
    assign framing_err = 1'b0;
`endif

    rx_holding_reg #(
        .W (FRAME_BITS)
    ) u_hold (
        .clk        (clk),
        .n_reset    (n_reset),
        .frame_done (frame_done),
        .frame_data (frame_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overrun    (overrun)
    );

endmodule
